// File: rtl/sub_16b_seq_pkg.sv
// Shared constants and FSM encoding for the nibble-serial 16-bit subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sub_16b_seq_pkg;

    localparam int WORD_W = 16;
    localparam int NIB_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_16b_seq_sub_4b.sv
// Combinational slice: a + ~b + c_in, with group propagate/generate.
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake.
import sub_16b_seq_pkg::*;

module sub_4b #(
    parameter int W = NIB_W
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] sum,
    output logic         c_out,
    output logic         p,
    output logic         g
);

    logic [W:0] full_sum;
    logic [W:0] gen_sum;

    // Slice arithmetic; g is the carry the slice makes on its own, p says a carry-in would ripple through.
    always_comb begin
        full_sum = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, c_in};
        gen_sum  = {1'b0, a} + {1'b0, ~b};
        sum      = full_sum[W-1:0];
        c_out    = full_sum[W];
        g        = gen_sum[W];
        p        = &(a ^ ~b);
    end

endmodule

// File: rtl/sub_16b_seq.sv
// Nibble-serial 16-bit subtractor: diff = a - b - b_in, with borrow/overflow/zero flags.
// Latency: result valid exactly 4 edges after the accept edge; accept-to-accept at least 6 edges.
// Backpressure: result held in DONE while out_ready=0; in_ready only in IDLE.
import sub_16b_seq_pkg::*;

module sub_16b_seq #(
    parameter int NIB_W = sub_16b_seq_pkg::NIB_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        b_in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] diff,
    output logic        b_out,
    output logic        ovf,
    output logic        zero,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int NUM_NIB = WORD_W / NIB_W;
    localparam int IDX_W   = $clog2(NUM_NIB);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic [WORD_W-1:0]  a_q;
    logic [WORD_W-1:0]  nb_q;
    logic [WORD_W-1:0]  diff_next;

    logic [NIB_W-1:0]   slice_a;
    logic [NIB_W-1:0]   slice_b;
    logic [NIB_W-1:0]   slice_sum;
    logic               slice_c_out;
    logic               slice_p;
    logic               slice_g;
    logic               slice_carry;
    logic               last_nib;

    // Subtrahend is stored complemented; the slice complements its b port itself,
    // so it is handed the original subtrahend bits of the current nibble.
    assign slice_a     = a_q[idx_q*NIB_W +: NIB_W];
    assign slice_b     = ~nb_q[idx_q*NIB_W +: NIB_W];
    assign slice_carry = slice_g | (slice_p & carry_q);
    assign last_nib    = (idx_q == LAST_IDX);

    sub_4b #(.W(NIB_W)) u_slice (
        .a     (slice_a),
        .b     (slice_b),
        .c_in  (carry_q),
        .sum   (slice_sum),
        .c_out (slice_c_out),
        .p     (slice_p),
        .g     (slice_g)
    );

    // Result word with the current nibble merged in.
    always_comb begin
        diff_next = diff;
        diff_next[idx_q*NIB_W +: NIB_W] = slice_sum;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the unused encoding falls back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_nib)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake flags are pure functions of state.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath: capture on accept, one nibble per RUN edge, flags on the final nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            nb_q    <= '0;
            diff    <= '0;
            b_out   <= 1'b0;
            ovf     <= 1'b0;
            zero    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        nb_q    <= ~b;
                        carry_q <= ~b_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    diff    <= diff_next;
                    carry_q <= slice_carry;
                    idx_q   <= idx_q + 1'b1;
                    if (last_nib) begin
                        b_out <= ~slice_c_out;
                        ovf   <= (a_q[WORD_W-1] != ~nb_q[WORD_W-1]) &&
                                 (diff_next[WORD_W-1] != a_q[WORD_W-1]);
                        zero  <= (diff_next == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_16b_seq.sv
module tb_sub_16b_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic        b_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] diff;
    logic        b_out;
    logic        ovf;
    logic        zero;
    logic        out_valid;
    logic        out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sub_16b_seq dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bi;
        logic [15:0] d;
        logic        bo;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic logic [18:0] model(input logic [15:0] ma, input logic [15:0] mb, input logic mbi);
        logic [16:0] r;
        int          sd;
        logic        ov;
        r  = {1'b0, ma} - {1'b0, mb} - {16'b0, mbi};
        sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbi);
        ov = (sd > 32767) || (sd < -32768);
        return {(r[15:0] == 16'h0000), ov, r[16], r[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (!in_ready) chk({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // One full operation: accept, scramble inputs, measure latency, check result,
    // hold under backpressure, then drain and confirm return to IDLE.
    task automatic do_op(input string tag, input logic [15:0] oa, input logic [15:0] ob,
                         input logic obi, input logic [18:0] exp, input int hold);
        int lat;
        wait_ready(tag);
        a = oa; b = ob; b_in = obi; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); b_in = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_result"}, {13'b0, zero, ovf, b_out, diff}, {13'b0, exp});
        for (int i = 0; i < hold; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            step();
            chk({tag, "_hold"}, {11'b0, out_valid, in_ready, zero, ovf, b_out, diff},
                {11'b0, 1'b1, 1'b0, exp});
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drain"}, {30'b0, out_valid, in_ready}, {30'b0, 1'b0, 1'b1});
    endtask

    initial begin
        logic [18:0] e;
        logic        seen;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rbi;

        vt[0] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vt[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vt[3] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1};
        vt[4] = '{16'h0005, 16'h0002, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0};
        vt[5] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b0};
        vt[6] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};

        rst = 1'b1; a = '0; b = '0; b_in = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        step();
        step();
        chk("reset_state", {11'b0, out_valid, in_ready, zero, ovf, b_out, diff},
            {11'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        rst = 1'b0;
        step();

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            do_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].bi,
                  {vt[i].z, vt[i].ov, vt[i].bo, vt[i].d}, (i == 0) ? 10 : 0);
        end

        // No accept on the DONE->IDLE edge even with in_valid held; accept on the next one.
        wait_ready("b2b");
        a = 16'h00F0; b = 16'h000F; b_in = 1'b0; in_valid = 1'b1;
        step();
        for (int i = 0; i < 4; i++) step();
        chk("b2b_done", 32'(out_valid), 32'd1);
        a = 16'h4000; b = 16'h0001; b_in = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("b2b_no_accept_on_return", {30'b0, out_valid, in_ready}, {30'b0, 1'b0, 1'b1});
        step();
        in_valid = 1'b0;
        chk("b2b_accept_next", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) step();
        e = model(16'h4000, 16'h0001, 1'b0);
        chk("b2b_second_result", {12'b0, out_valid, zero, ovf, b_out, diff}, {12'b0, 1'b1, e});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset on the RUN edge that would process nibble 2.
        wait_ready("rst_mid");
        a = 16'hABCD; b = 16'h1234; b_in = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_state", {11'b0, out_valid, in_ready, zero, ovf, b_out, diff},
            {11'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("rst_mid_no_result", 32'(seen), 32'd0);
        do_op("after_rst", 16'h2468, 16'h1357, 1'b1, model(16'h2468, 16'h1357, 1'b1), 1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rbi = 1'($urandom);
            if (i % 8 == 0) rb = ra;
            do_op($sformatf("rand%0d", i), ra, rb, rbi, model(ra, rb, rbi),
                  int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
